// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   state_t         loader FSM states
//   HDR_BYTES       number of word-count bytes at the start of a stream
//   BYTES_PER_WORD  bytes packed into one instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer
// Packs accepted bytes into a 32-bit little-endian word (first byte lands in
// bits 7:0) and flags the cycle in which the final byte of a word is taken.
// Ports:
//   CLOCK, RST   system clock, synchronous active-high reset
//   i_byte       incoming byte
//   i_take       i_byte is consumed into the current word this cycle
//   o_word       completed word (valid while o_complete is high)
//   o_complete   i_take is delivering the last byte of the word
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RST,
  input  logic [7:0]  i_byte,
  input  logic        i_take,
  output logic [31:0] o_word,
  output logic        o_complete
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_bytes;

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_bytes <= '0;
    end else if (i_take) begin
      // counter wraps to 0 after the last byte, which starts the next word
      r_cnt   <= r_cnt + 2'd1;
      r_bytes <= {i_byte, r_bytes[23:8]};
    end
  end

  // the word is completed combinationally so the write can be registered on
  // the same edge that accepts the last byte
  assign o_word     = {i_byte, r_bytes};
  assign o_complete = i_take && (r_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Write side of the instruction memory. Receives a byte stream (16-bit LE word
// count, then the words LSB first, then an optional XOR checksum byte), writes
// the words to consecutive addresses and releases the core from reset once a
// complete image is in memory.
// Build option: define IMEM_LOADER_CHECKSUM_EN to expect and verify the
// trailing checksum byte; undefined, the load ends on the last word.
// Ports:
//   CLOCK, RST            system clock, synchronous active-high reset
//   rx_data/valid/ready   byte stream handshake
//   wr_en/addr/data       instruction-memory write port (one-cycle strobe)
//   core_rst_n            active-low core reset, released on success
//   busy/done/error       loader status; done and error are sticky
//
// state  | meaning
// S_LEN0 | waiting for word-count low byte
// S_LEN1 | waiting for word-count high byte
// S_DATA | receiving and writing image words
// S_CSUM | waiting for checksum byte
// S_DONE | image loaded, core released (terminal)
// S_ERR  | load failed, core held in reset (terminal)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ANCHO  = 32,
  parameter int LARGO  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ANCHO-1:0]  wr_data,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] LARGO_W = 17'(LARGO);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t              r_state;
  logic [7:0]          r_len_lo;
  logic [15:0]         r_n;
  logic [15:0]         r_idx;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ANCHO-1:0]    r_wr_data;

  logic                w_take;
  logic                w_pack_take;
  logic [15:0]         w_len;
  logic [31:0]         w_word;
  logic                w_word_done;

  assign w_take      = rx_valid && rx_ready;
  assign w_pack_take = w_take && (r_state == S_DATA);
  assign w_len       = {rx_data, r_len_lo};

  word_packer u_packer (
    .CLOCK      (CLOCK),
    .RST        (RST),
    .i_byte     (rx_data),
    .i_take     (w_pack_take),
    .o_word     (w_word),
    .o_complete (w_word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge CLOCK) begin
    if (RST)         r_csum <= '0;
    else if (w_take) r_csum <= r_csum ^ rx_data;
  end
`endif

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_state   <= S_LEN0;
      r_len_lo  <= '0;
      r_n       <= '0;
      r_idx     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_LEN0: begin
          if (w_take) begin
            r_len_lo <= rx_data;
            r_state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_take) begin
            r_n <= w_len;
            if ({1'b0, w_len} > LARGO_W) r_state <= S_ERR;
            else if (w_len == 16'd0)     r_state <= S_TAIL;
            else                         r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_word_done) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx[ADDR_W-1:0];
            r_wr_data <= ANCHO'(w_word);
            r_idx     <= r_idx + 16'd1;
            if (r_idx == r_n - 16'd1) r_state <= S_TAIL;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          // r_csum holds the XOR of everything before the checksum byte
          if (w_take) r_state <= (rx_data == r_csum) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  assign rx_ready   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign busy       = rx_ready;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign core_rst_n = done;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

endmodule
